// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared constants, fetch-state encoding and IF/ID bundle
package instruction_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch unit bus: hazard/redirect inputs, imem port, IF/ID outputs
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic            Stall;
    logic            Redirect;
    logic [XLEN-1:0] RedirectTarget;
    logic [XLEN-1:0] Address;
    logic [XLEN-1:0] Instruction;
    logic [XLEN-1:0] IFID_Instruction;
    logic [XLEN-1:0] IFID_PCPlus4;
    logic            IFID_Valid;
    logic            Halted;
    logic [XLEN-1:0] FetchCount;

    modport master (
        input  Stall, Redirect, RedirectTarget, Instruction,
        output Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted, FetchCount
    );

    modport slave (
        output Stall, Redirect, RedirectTarget, Instruction,
        input  Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid, Halted, FetchCount
    );

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// rtl/instruction_fetch_unit_pc_register.sv - program counter with load enable and async reset
module pc_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            load_i,
    input  logic [XLEN-1:0] next_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= next_pc_i;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage: PC, next-PC select, IF/ID register, halt FSM
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic                      Clk,
    input  logic                      Reset,
    instruction_fetch_unit_if.master  fetch
);

    fetch_state_e    state_q, state_d;
    ifid_t           ifid_q, ifid_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            pc_load;

    pc_register u_pc (
        .Clk       (Clk),
        .Reset     (Reset),
        .load_i    (pc_load),
        .next_pc_i (next_pc),
        .pc_o      (pc)
    );

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            ifid_q  <= IFID_BUBBLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    // Redirect outranks everything, including a halt word sitting in its shadow.
    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_q;
        count_d = count_q;
        pc_load = 1'b0;
        next_pc = pc_plus4;
        unique case (state_q)
            RUN: begin
                if (fetch.Redirect) begin
                    pc_load = 1'b1;
                    next_pc = align_word(fetch.RedirectTarget);
                    ifid_d  = IFID_BUBBLE;
                end else if (fetch.Stall) begin
                    ifid_d  = ifid_q;
                end else if (fetch.Instruction == HALT_WORD) begin
                    ifid_d  = IFID_BUBBLE;
                    state_d = HALTED;
                end else begin
                    pc_load = 1'b1;
                    next_pc = pc_plus4;
                    ifid_d  = '{instr: fetch.Instruction, pc_plus4: pc_plus4, valid: 1'b1};
                    count_d = count_q + 32'd1;
                end
            end
            HALTED: begin
                ifid_d = IFID_BUBBLE;
                if (fetch.Redirect) begin
                    pc_load = 1'b1;
                    next_pc = align_word(fetch.RedirectTarget);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign fetch.Address          = pc;
    assign fetch.IFID_Instruction = ifid_q.instr;
    assign fetch.IFID_PCPlus4     = ifid_q.pc_plus4;
    assign fetch.IFID_Valid       = ifid_q.valid;
    assign fetch.Halted           = (state_q == HALTED);
    assign fetch.FetchCount       = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the byte address into the instruction memory, and latches the returned word into the IF/ID pipeline register for decode. Handles sequential PC advance, branch/jump redirects resolved downstream, load-use stalls, and a halt state entered on a dedicated halt word. Everything downstream sees only `IFID_*` outputs; the instruction memory sees only `Address`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- `NOP_WORD`, 32'h0000_0000, word injected into IF/ID on bubble (sll $0,$0,0).

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Stall`  in  1  hazard unit: hold PC and IF/ID.
- `Redirect`  in  1  taken branch or jump resolved downstream.
- `RedirectTarget`  in  32  new PC on `Redirect`.
- `Address`  out  32  byte address to instruction memory (= PC register).
- `Instruction`  in  32  word returned combinationally by instruction memory.
- `IFID_Instruction`  out  32  latched instruction.
- `IFID_PCPlus4`  out  32  PC+4 of latched instruction.
- `IFID_Valid`  out  1  latched slot holds a real instruction.
- `Halted`  out  1  fetch stopped on `HALT_WORD`.
- `FetchCount`  out  32  number of valid instructions latched into IF/ID.

## Operation
- State machine: RUN, HALTED. Reset -> RUN.
- RUN, priority per cycle: Redirect > Stall > halt detect > normal.
  - Redirect: PC <= {RedirectTarget[31:2], 2'b00}; IF/ID <= bubble (NOP_WORD, Valid 0, PCPlus4 0). Stall ignored. Halt word fetched this cycle squashed; stay RUN.
  - Stall (no Redirect): PC, IF/ID, FetchCount hold.
  - `Instruction == HALT_WORD`: PC holds; IF/ID <= bubble; -> HALTED. Halt word never enters IF/ID.
  - Normal: PC <= PC+4; IF/ID <= {Instruction, PC+4, Valid 1}; FetchCount += 1.
- HALTED: PC holds; IF/ID <= bubble every cycle; `Redirect` -> RUN with PC <= target (resumes fetch; covers a halt fetched in a branch shadow). `Stall` ignored. `Halted` = 1 only in HALTED.
- Arithmetic: PC+4 and FetchCount wrap mod 2^32; PC low two bits always 0.
- Reset outputs: PC = RESET_PC, IFID_Instruction = NOP_WORD, IFID_PCPlus4 = 0, IFID_Valid = 0, Halted = 0, FetchCount = 0.

## Timing
- `Address` is the PC register output directly; instruction memory read completes in the same cycle; IF/ID captures on the next rising edge: 1-cycle fetch latency.
- First valid IF/ID output: first edge after Reset deassertion, holding word at RESET_PC.
- Redirect asserted in cycle N: cycle N+1 `Address` = target, IF/ID = bubble; cycle N+2 IF/ID holds target word.
- Stall is level-sensitive; every stalled cycle is a full hold. Stall deasserting resumes with no lost or duplicated instruction.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of Stall/Redirect/state.

## Structure
- Shared package: `RESET_PC`, `NOP_WORD`, `HALT_WORD` defaults, fetch-state encoding (RUN=0, HALTED=1), IF/ID bundle field widths.
- One natural sub-module: `pc_register` (32-bit PC with async reset to RESET_PC, load enable, next-PC input); next-PC mux, IF/ID register, state machine, counter stay in the top.

## Test plan
- Reset release, memory words 0,4,8 at addresses 0,4,8, no stall -> IFID_PCPlus4 = 4,8,12 on consecutive cycles, IFID_Valid = 1, FetchCount = 1,2,3.
- Stall held 3 cycles while Address = 0x10 -> Address stays 0x10, IF/ID unchanged, FetchCount unchanged; release -> next IF/ID word from 0x10.
- Redirect with RedirectTarget = 0x43 while Stall = 1 -> next Address = 0x40, IFID_Valid = 0 for one cycle, then word at 0x40 latched.
- HALT_WORD at 0x20 -> Halted = 1, Address frozen at 0x20, IFID_Valid = 0 every cycle; later Redirect to 0x8 -> Halted = 0, Address = 0x8.
- HALT_WORD fetched same cycle as Redirect to 0x100 -> Halted stays 0, Address = 0x100.
- Reset asserted mid-run (PC = 0x3C, FetchCount = 15) between edges -> all outputs at reset values immediately, before the next clock edge.
